// File: rtl/spi_sclk_engine.sv
// SPI master serial-clock engine: SETUP/RUN/HOLD sequencing, CPOL/CPHA strobes, busy/done status.
// Optional chip select output o_cs_n is enabled with `define SPI_SCLK_ENGINE_CS_EN.
module spi_sclk_engine #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [DIV_W-1:0] i_div_half,
   input  logic             i_cpol,
   input  logic             i_cpha,
   input  logic [CNT_W-1:0] i_nbits,
   output logic             o_sclk,
   output logic             o_busy,
   output logic             o_sample,
   output logic             o_shift,
   output logic             o_mid,
   output logic [CNT_W-1:0] o_bit_idx,
   output logic             o_done
`ifdef SPI_SCLK_ENGINE_CS_EN
  ,output logic             o_cs_n
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_HOLD} state_t;

   localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO_D = DIV_W'(2);
   localparam logic [CNT_W:0]   ONE_E = (CNT_W+1)'(1);

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [CNT_W:0]     edge_q, edge_d;
   logic [CNT_W-1:0]   nbits_q, nbits_d;
   logic               cpol_q, cpol_d;
   logic               cpha_q, cpha_d;
   logic               sclk_q, sclk_d;
   logic               busy_q, busy_d;
   logic               sample_q, sample_d;
   logic               shift_q, shift_d;
   logic               mid_q, mid_d;
   logic [CNT_W-1:0]   bit_idx_q, bit_idx_d;
   logic               done_q, done_d;
`ifdef SPI_SCLK_ENGINE_CS_EN
   logic               cs_n_q, cs_n_d;
`endif

   logic               last_cnt;
   logic               leading;
   logic               last_edge;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      edge_d    = edge_q;
      nbits_d   = nbits_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      sclk_d    = sclk_q;
      busy_d    = busy_q;
      sample_d  = 1'b0;
      shift_d   = 1'b0;
      mid_d     = 1'b0;
      done_d    = 1'b0;
      bit_idx_d = bit_idx_q + {{(CNT_W-1){1'b0}}, sample_q};
`ifdef SPI_SCLK_ENGINE_CS_EN
      cs_n_d    = cs_n_q;
`endif
      last_cnt  = (cnt_q == div_q - ONE_D);
      // Edge number being produced is edge_q+1; odd numbers are leading edges.
      leading   = ~edge_q[0];
      last_edge = ((edge_q + ONE_E) == {nbits_q, 1'b0});

      unique case (state_q)
         S_IDLE: begin
            sclk_d = cpol_q;
            busy_d = 1'b0;
`ifdef SPI_SCLK_ENGINE_CS_EN
            cs_n_d = 1'b1;
`endif
            if (i_start && !i_abort) begin
               div_d     = (i_div_half < TWO_D) ? TWO_D : i_div_half;
               cpol_d    = i_cpol;
               cpha_d    = i_cpha;
               nbits_d   = i_nbits;
               sclk_d    = i_cpol;
               bit_idx_d = '0;
               cnt_d     = '0;
               edge_d    = '0;
               if (i_nbits == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_SETUP;
                  busy_d  = 1'b1;
                  shift_d = ~i_cpha;
`ifdef SPI_SCLK_ENGINE_CS_EN
                  cs_n_d  = 1'b0;
`endif
               end
            end
         end
         S_SETUP: begin
            if (last_cnt) begin
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q + ONE_D;
            end
         end
         S_RUN: begin
            mid_d = (cnt_q == (div_q >> 1) - ONE_D);
            if (last_cnt) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               edge_d = edge_q + ONE_E;
               if (cpha_q) begin
                  shift_d  = leading;
                  sample_d = ~leading;
               end else begin
                  sample_d = leading;
                  shift_d  = ~leading && !last_edge;
               end
               if (last_edge) state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + ONE_D;
            end
         end
         S_HOLD: begin
            if (last_cnt) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
`ifdef SPI_SCLK_ENGINE_CS_EN
               cs_n_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + ONE_D;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides everything, including a same-cycle start.
      if (i_abort) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         edge_d   = '0;
         sclk_d   = cpol_q;
         busy_d   = 1'b0;
         sample_d = 1'b0;
         shift_d  = 1'b0;
         mid_d    = 1'b0;
         done_d   = 1'b0;
         div_d    = div_q;
         cpol_d   = cpol_q;
         cpha_d   = cpha_q;
         nbits_d  = nbits_q;
`ifdef SPI_SCLK_ENGINE_CS_EN
         cs_n_d   = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         edge_q    <= '0;
         nbits_q   <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         sclk_q    <= 1'b0;
         busy_q    <= 1'b0;
         sample_q  <= 1'b0;
         shift_q   <= 1'b0;
         mid_q     <= 1'b0;
         bit_idx_q <= '0;
         done_q    <= 1'b0;
`ifdef SPI_SCLK_ENGINE_CS_EN
         cs_n_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         edge_q    <= edge_d;
         nbits_q   <= nbits_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         sclk_q    <= sclk_d;
         busy_q    <= busy_d;
         sample_q  <= sample_d;
         shift_q   <= shift_d;
         mid_q     <= mid_d;
         bit_idx_q <= bit_idx_d;
         done_q    <= done_d;
`ifdef SPI_SCLK_ENGINE_CS_EN
         cs_n_q    <= cs_n_d;
`endif
      end
   end

   assign o_sclk    = sclk_q;
   assign o_busy    = busy_q;
   assign o_sample  = sample_q;
   assign o_shift   = shift_q;
   assign o_mid     = mid_q;
   assign o_bit_idx = bit_idx_q;
   assign o_done    = done_q;
`ifdef SPI_SCLK_ENGINE_CS_EN
   assign o_cs_n    = cs_n_q;
`endif

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: per-transfer expectations queued at start, compared after o_done.
module tb_spi_sclk_engine;

   localparam int DIV_W = 8;
   localparam int CNT_W = 6;

   localparam int K_BUSY = 0, K_SAMP = 1, K_SHIFT = 2, K_MID = 3, K_RISE = 4, K_FALL = 5;
   localparam int K_SRISE = 6, K_SFALL = 7, K_SHRISE = 8, K_SHFALL = 9, K_DONE = 10;
   localparam int K_CSLOW = 11, K_CSMIS = 12, NK = 13;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_start = 1'b0;
   logic             i_abort = 1'b0;
   logic [DIV_W-1:0] i_div_half = '0;
   logic             i_cpol = 1'b0;
   logic             i_cpha = 1'b0;
   logic [CNT_W-1:0] i_nbits = '0;
   logic             o_sclk, o_busy, o_sample, o_shift, o_mid, o_done;
   logic [CNT_W-1:0] o_bit_idx;
`ifdef SPI_SCLK_ENGINE_CS_EN
   logic             o_cs_n;
`endif

   spi_sclk_engine #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (i_start),
      .i_abort    (i_abort),
      .i_div_half (i_div_half),
      .i_cpol     (i_cpol),
      .i_cpha     (i_cpha),
      .i_nbits    (i_nbits),
      .o_sclk     (o_sclk),
      .o_busy     (o_busy),
      .o_sample   (o_sample),
      .o_shift    (o_shift),
      .o_mid      (o_mid),
      .o_bit_idx  (o_bit_idx),
      .o_done     (o_done)
`ifdef SPI_SCLK_ENGINE_CS_EN
     ,.o_cs_n     (o_cs_n)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int v [NK];
      int idx;
      int period;
   } exp_t;

   exp_t sb [$];
   int   mon [NK] = '{default: 0};
   int   cyc = 0;
   int   last_rise = -1;
   int   last_period = 0;
   logic prev_sclk = 1'b0;
   logic prev_busy = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   // Event counters sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      cyc++;
      if (o_busy)   mon[K_BUSY]++;
      if (o_sample) mon[K_SAMP]++;
      if (o_shift)  mon[K_SHIFT]++;
      if (o_mid)    mon[K_MID]++;
      if (o_done)   mon[K_DONE]++;
      if (o_busy && prev_busy && (o_sclk != prev_sclk)) begin
         if (o_sclk) begin
            mon[K_RISE]++;
            if (o_sample) mon[K_SRISE]++;
            if (o_shift)  mon[K_SHRISE]++;
            if (last_rise >= 0) last_period = cyc - last_rise;
            last_rise = cyc;
         end else begin
            mon[K_FALL]++;
            if (o_sample) mon[K_SFALL]++;
            if (o_shift)  mon[K_SHFALL]++;
         end
      end
      if (!o_busy) last_rise = -1;
`ifdef SPI_SCLK_ENGINE_CS_EN
      if (!o_cs_n) mon[K_CSLOW]++;
      if ((!o_cs_n) != o_busy) mon[K_CSMIS]++;
`endif
      prev_sclk = o_sclk;
      prev_busy = o_busy;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic run_xfer(input int div, input bit cpol, input bit cpha, input int n, input bit disturb);
      exp_t e;
      int   d, shedges, snap [NK];
      bit   same, seen;
      string names [NK] = '{"busy", "samp", "shift", "mid", "rise", "fall", "samp_rise",
                            "samp_fall", "shift_rise", "shift_fall", "done", "cs_low", "cs_mis"};
      d    = (div < 2) ? 2 : div;
      same = (cpol == cpha);
      shedges = (n == 0) ? 0 : (cpha ? n : n - 1);
      e.v[K_BUSY]   = (n == 0) ? 0 : (2 * n + 2) * d;
      e.v[K_SAMP]   = n;
      e.v[K_SHIFT]  = n;
      e.v[K_MID]    = 2 * n;
      e.v[K_RISE]   = n;
      e.v[K_FALL]   = n;
      e.v[K_SRISE]  = same ? n : 0;
      e.v[K_SFALL]  = same ? 0 : n;
      e.v[K_SHRISE] = same ? 0 : shedges;
      e.v[K_SHFALL] = same ? shedges : 0;
      e.v[K_DONE]   = 1;
`ifdef SPI_SCLK_ENGINE_CS_EN
      e.v[K_CSLOW]  = e.v[K_BUSY];
`else
      e.v[K_CSLOW]  = 0;
`endif
      e.v[K_CSMIS]  = 0;
      e.idx    = n;
      e.period = 2 * d;
      sb.push_back(e);

      snap = mon;
      @(posedge clk); #1;
      i_div_half = DIV_W'(div);
      i_cpol = cpol; i_cpha = cpha; i_nbits = CNT_W'(n);
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (o_done) begin
            seen = 1'b1;
            break;
         end
         if (disturb) begin
            i_start    = ($urandom_range(0, 1) == 1);
            i_div_half = DIV_W'($urandom_range(0, 255));
         end
      end
      i_start = 1'b0;
      i_div_half = DIV_W'(div);
      chk("done_seen", int'(seen), 1);
      repeat (2) @(negedge clk);
      e = sb.pop_front();
      for (int k = 0; k < NK; k++) chk(names[k], mon[k] - snap[k], e.v[k]);
      chk("bit_idx", int'(o_bit_idx), e.idx);
      if (n >= 2) chk("period", last_period, e.period);
      chk("idle_sclk", int'(o_sclk), int'(cpol));
   endtask

   initial begin : main
      int snap [NK];
      #23 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_sclk", int'(o_sclk), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_idx", int'(o_bit_idx), 0);
      chk("rst_strobes", int'({o_sample, o_shift, o_mid, o_done}), 0);
`ifdef SPI_SCLK_ENGINE_CS_EN
      chk("rst_cs_n", int'(o_cs_n), 1);
`endif

      run_xfer(4, 1'b0, 1'b0, 8, 1'b0);
      run_xfer(4, 1'b1, 1'b1, 8, 1'b0);
      run_xfer(0, 1'b0, 1'b0, 2, 1'b0);
      run_xfer(1, 1'b0, 1'b1, 2, 1'b0);
      run_xfer(3, 1'b1, 1'b0, 5, 1'b0);
      run_xfer(5, 1'b0, 1'b1, 3, 1'b0);

      // Abort in the fifth RUN cycle of an N=4, D=3 transfer with cpol=1.
      snap = mon;
      @(posedge clk); #1;
      i_div_half = 8'd3; i_cpol = 1'b1; i_cpha = 1'b0; i_nbits = 6'd4; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (7) @(posedge clk);
      #1 i_abort = 1'b1;
      @(posedge clk); #1;
      i_abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_sclk", int'(o_sclk), 1);
      chk("abort_strobes", int'({o_sample, o_shift, o_mid}), 0);
`ifdef SPI_SCLK_ENGINE_CS_EN
      chk("abort_cs_n", int'(o_cs_n), 1);
`endif
      repeat (20) @(negedge clk);
      chk("abort_no_done", mon[K_DONE] - snap[K_DONE], 0);
      run_xfer(3, 1'b0, 1'b0, 4, 1'b0);

      // Start and abort together in IDLE: the start and its cpol are dropped.
      snap = mon;
      @(posedge clk); #1;
      i_cpol = 1'b1; i_nbits = 6'd4; i_start = 1'b1; i_abort = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0; i_abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("startabort_busy", mon[K_BUSY] - snap[K_BUSY], 0);
      chk("startabort_sclk", int'(o_sclk), 0);
      chk("startabort_done", mon[K_DONE] - snap[K_DONE], 0);

      run_xfer(4, 1'b0, 1'b0, 8, 1'b1);

      // Zero-bit transfer: done next cycle, no busy and no SCLK activity.
      snap = mon;
      @(posedge clk); #1;
      i_div_half = 8'd4; i_cpol = 1'b0; i_cpha = 1'b0; i_nbits = 6'd0; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      @(negedge clk);
      chk("n0_done", int'(o_done), 1);
      chk("n0_busy", int'(o_busy), 0);
      chk("n0_idx", int'(o_bit_idx), 0);
      repeat (6) @(negedge clk);
      chk("n0_strobes", mon[K_SAMP] + mon[K_SHIFT] + mon[K_MID] - snap[K_SAMP] - snap[K_SHIFT] - snap[K_MID], 0);
      chk("n0_sclk", int'(o_sclk), 0);

      // Asynchronous reset in the middle of RUN.
      snap = mon;
      @(posedge clk); #1;
      i_div_half = 8'd4; i_cpol = 1'b1; i_cpha = 1'b0; i_nbits = 6'd8; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mrst_sclk", int'(o_sclk), 0);
      chk("mrst_busy", int'(o_busy), 0);
      chk("mrst_idx", int'(o_bit_idx), 0);
      chk("mrst_strobes", int'({o_sample, o_shift, o_mid, o_done}), 0);
`ifdef SPI_SCLK_ENGINE_CS_EN
      chk("mrst_cs_n", int'(o_cs_n), 1);
`endif
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("mrst_no_done", mon[K_DONE] - snap[K_DONE], 0);
      run_xfer(4, 1'b0, 1'b0, 8, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
